sa_feed_scheduler: RTL

- Sequences the ROWS column-buffer FIFOs that feed the systolic array's west edge.
- Waits until every row FIFO holds a full tile, then streams it with a diagonal (skewed) wavefront: row r starts r cycles after row 0.
- Drives per-row FIFO read enables and shift-register enables, supports back-pressure from the PE array, and reports tile completion and underflow.

---
 rtl/sa_pkg.sv | 35 +++
 rtl/sa_skew_window.sv | 21 ++
 rtl/sa_feed_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array west-edge feed scheduler.
// SA_FEED_ZERO_FLUSH_EN adds a FLUSH state that drains the array with zeros.
package sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FILL = 3'd1,
        ST_STREAM    = 3'd2,
`ifdef SA_FEED_ZERO_FLUSH_EN
        ST_FLUSH     = 3'd3,
`endif
        ST_DONE      = 3'd4
    } sa_state_e;

    // Widest packed occupancy bus the slice helper accepts.
    localparam int OCC_BUS_MAX = 1024;

    // Number of advancing cycles needed to push one skewed tile through.
    function automatic int stream_len(input int rows, input int tile_len);
        return tile_len + rows - 1;
    endfunction

    // Extract one row's occupancy from a packed bus, zero-extended to 32 bits.
    function automatic logic [31:0] occ_slice(input logic [OCC_BUS_MAX-1:0] bus,
                                              input int row,
                                              input int width);
        logic [31:0] res;
        res = 32'(bus >> (row * width));
        if (width < 32) begin
            res = res & ((32'd1 << width) - 32'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/sa_skew_window.sv
// Diagonal wavefront decode: row r is active while r <= count < r + TILE_LEN.
// Shared with the output de-skew logic on the far side of the array.
module sa_skew_window #(
    parameter int ROWS     = 4,
    parameter int TILE_LEN = 9,
    parameter int CW       = 4
) (
    input  logic [CW-1:0]   i_count,
    output logic [ROWS-1:0] o_active
);

    // Per-row window compare against the shared skew counter.
    always_comb begin
        o_active = '0;
        for (int r = 0; r < ROWS; r++) begin
            o_active[r] = (32'(i_count) >= 32'(r)) &&
                          (32'(i_count) < 32'(r + TILE_LEN));
        end
    end

endmodule

// File: rtl/sa_feed_scheduler.sv
// Feed scheduler for the systolic array west edge: waits for a full tile in
// every row FIFO, then streams it with a one-cycle-per-row skew.
// Optional macro SA_FEED_ZERO_FLUSH_EN adds o_zero_insert and a FLUSH state.
module sa_feed_scheduler
    import sa_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int TILE_LEN = 9,
    parameter int W_ADDR   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_continuous,
    input  logic [ROWS-1:0]          i_fifo_empty,
    input  logic [ROWS*(W_ADDR+1)-1:0] i_occupants,
    input  logic                     i_pe_ready,
    output logic [ROWS-1:0]          o_read_enable,
    output logic [ROWS-1:0]          o_sr_enable,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [15:0]              o_tile_cnt
`ifdef SA_FEED_ZERO_FLUSH_EN
    ,
    output logic                     o_zero_insert
`endif
);

    localparam int OCC_W = W_ADDR + 1;
    localparam int CW    = $clog2(TILE_LEN + ROWS);
    localparam logic [CW-1:0] LAST_CNT = CW'(stream_len(ROWS, TILE_LEN) - 1);

    // A tile longer than the FIFO occupancy can express could never start.
    if (TILE_LEN > (2 ** OCC_W) - 1) begin : g_bad_tile_len
        $error("sa_feed_scheduler: TILE_LEN exceeds occupancy range");
    end

    sa_state_e              r_state;
    sa_state_e              w_next_state;
    logic [CW-1:0]          r_count;
    logic [ROWS-1:0]        r_sr_enable;
    logic                   r_err;
    logic [15:0]            r_tile_cnt;
    logic [ROWS-1:0]        w_window;
    logic [ROWS-1:0]        w_scheduled;
    logic                   w_underflow;
    logic                   w_all_filled;
    logic [OCC_BUS_MAX-1:0] w_occ_bus;

`ifdef SA_FEED_ZERO_FLUSH_EN
    localparam int FCW = $clog2(ROWS + 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(ROWS - 1);
    logic [FCW-1:0]         r_flush_cnt;
`endif

    assign w_occ_bus = OCC_BUS_MAX'(i_occupants);

    // A tile may start only when every row holds a full tile and is not empty.
    always_comb begin
        w_all_filled = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            if ((occ_slice(w_occ_bus, r, OCC_W) < 32'(TILE_LEN)) || i_fifo_empty[r]) begin
                w_all_filled = 1'b0;
            end
        end
    end

    sa_skew_window #(
        .ROWS     (ROWS),
        .TILE_LEN (TILE_LEN),
        .CW       (CW)
    ) u_skew_window (
        .i_count  (r_count),
        .o_active (w_window)
    );

    // Rows scheduled this cycle; reset and back-pressure kill every read.
    assign w_scheduled   = (r_state == ST_STREAM && i_pe_ready && !i_rst) ? w_window : '0;
    assign o_read_enable = w_scheduled & ~i_fifo_empty;
    assign w_underflow   = |(w_scheduled & i_fifo_empty);

    // Next-state decode for the tile sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_WAIT_FILL;
                end
            end
            ST_WAIT_FILL: begin
                if (w_all_filled) begin
                    w_next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (i_pe_ready && r_count == LAST_CNT) begin
`ifdef SA_FEED_ZERO_FLUSH_EN
                    w_next_state = ST_FLUSH;
`else
                    w_next_state = ST_DONE;
`endif
                end
            end
`ifdef SA_FEED_ZERO_FLUSH_EN
            ST_FLUSH: begin
                if (i_pe_ready && r_flush_cnt == FLUSH_LAST) begin
                    w_next_state = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_next_state = i_continuous ? ST_WAIT_FILL : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Skew counter: cleared while waiting, advances only on accepted cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (r_state == ST_WAIT_FILL) begin
            r_count <= '0;
        end else if (r_state == ST_STREAM && i_pe_ready && r_count != LAST_CNT) begin
            r_count <= r_count + CW'(1);
        end
    end

`ifdef SA_FEED_ZERO_FLUSH_EN
    // Flush counter: counts accepted zero-insert cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flush_cnt <= '0;
        end else if (r_state != ST_FLUSH) begin
            r_flush_cnt <= '0;
        end else if (i_pe_ready && r_flush_cnt != FLUSH_LAST) begin
            r_flush_cnt <= r_flush_cnt + FCW'(1);
        end
    end
`endif

    // Shift-register enables trail the FIFO reads by the 1-cycle read latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr_enable <= '0;
        end else begin
            r_sr_enable <= o_read_enable;
        end
    end

    // Sticky underflow flag, only cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_underflow) begin
            r_err <= 1'b1;
        end
    end

    // Completed-tile counter, bumped once per DONE cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tile_cnt <= '0;
        end else if (r_state == ST_DONE) begin
            r_tile_cnt <= r_tile_cnt + 16'd1;
        end
    end

`ifdef SA_FEED_ZERO_FLUSH_EN
    assign o_sr_enable   = r_sr_enable | ((r_state == ST_FLUSH) ? {ROWS{1'b1}} : '0);
    assign o_zero_insert = (r_state == ST_FLUSH);
`else
    assign o_sr_enable   = r_sr_enable;
`endif
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);
    assign o_err      = r_err;
    assign o_tile_cnt = r_tile_cnt;

endmodule
